// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : writeback_unit
// Brief    : Merges ALU results and load responses into one registered
//            register-file write stream, with load formatting and x0 filtering.
//            Optional WB_FORWARD_EN adds combinational next-write bypass ports.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_unit #(
    parameter int XLEN       = 32,
    parameter int ADDRESSLEN = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [ADDRESSLEN-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  stall,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDRESSLEN-1:0] ld_rd,
    input  logic [2:0]            ld_funct3,
    input  logic [1:0]            ld_offset,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  busy,
`ifdef WB_FORWARD_EN
    output logic                  fwd_valid,
    output logic [ADDRESSLEN-1:0] fwd_rd,
    output logic [XLEN-1:0]       fwd_data,
`endif
    output logic [ADDRESSLEN-1:0] rd,
    output logic [XLEN-1:0]       data,
    output logic                  wEn
);

    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_WAIT_MEM = 1'b1;

    logic [0:0]            r_state;
    logic [ADDRESSLEN-1:0] r_ld_rd;
    logic [2:0]            r_ld_funct3;
    logic [1:0]            r_ld_offset;
    logic                  r_hold_valid;
    logic [ADDRESSLEN-1:0] r_hold_rd;
    logic [XLEN-1:0]       r_hold_data;
    logic                  r_wen;
    logic [ADDRESSLEN-1:0] r_rd;
    logic [XLEN-1:0]       r_data;

    logic                  w_ld_resp;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [XLEN-1:0]       w_ld_data;
    logic                  w_sel;
    logic [ADDRESSLEN-1:0] w_sel_rd;
    logic [XLEN-1:0]       w_sel_data;
    logic                  w_hold_load;
    logic                  w_hold_drain;
    logic                  w_wen_next;

    assign w_ld_resp = (r_state == c_WAIT_MEM) && mem_rvalid;
    assign ld_ready  = (r_state == c_IDLE);
    assign busy      = (r_state == c_WAIT_MEM);
    assign stall     = r_hold_valid;

    // Halfword lane uses only offset[1]; misaligned halves fold onto it.
    assign w_byte = mem_rdata[{r_ld_offset, 3'b000} +: 8];
    assign w_half = r_ld_offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        w_ld_data = mem_rdata;
        case (r_ld_funct3)
            3'b000:  w_ld_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_ld_data = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100:  w_ld_data = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_ld_data = {{(XLEN-16){1'b0}}, w_half};
            default: w_ld_data = mem_rdata;
        endcase
    end

    // Priority: load response, then hold buffer, then a fresh ALU result.
    always_comb begin
        w_sel        = 1'b0;
        w_sel_rd     = r_rd;
        w_sel_data   = r_data;
        w_hold_load  = 1'b0;
        w_hold_drain = 1'b0;
        if (w_ld_resp) begin
            w_sel       = 1'b1;
            w_sel_rd    = r_ld_rd;
            w_sel_data  = w_ld_data;
            w_hold_load = alu_valid && !r_hold_valid;
        end else if (r_hold_valid) begin
            w_sel        = 1'b1;
            w_sel_rd     = r_hold_rd;
            w_sel_data   = r_hold_data;
            w_hold_drain = 1'b1;
        end else if (alu_valid) begin
            w_sel      = 1'b1;
            w_sel_rd   = alu_rd;
            w_sel_data = alu_data;
        end
    end

    assign w_wen_next = w_sel && (w_sel_rd != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_ld_rd      <= '0;
            r_ld_funct3  <= '0;
            r_ld_offset  <= '0;
            r_hold_valid <= 1'b0;
            r_hold_rd    <= '0;
            r_hold_data  <= '0;
            r_wen        <= 1'b0;
            r_rd         <= '0;
            r_data       <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (ld_valid) begin
                        r_state     <= c_WAIT_MEM;
                        r_ld_rd     <= ld_rd;
                        r_ld_funct3 <= ld_funct3;
                        r_ld_offset <= ld_offset;
                    end
                end
                default: begin
                    if (mem_rvalid) r_state <= c_IDLE;
                end
            endcase

            if (w_hold_load) begin
                r_hold_valid <= 1'b1;
                r_hold_rd    <= alu_rd;
                r_hold_data  <= alu_data;
            end else if (w_hold_drain) begin
                r_hold_valid <= 1'b0;
            end

            r_wen <= w_wen_next;
            if (w_sel) begin
                r_rd   <= w_sel_rd;
                r_data <= w_sel_data;
            end
        end
    end

    assign wEn  = r_wen;
    assign rd   = r_rd;
    assign data = r_data;

`ifdef WB_FORWARD_EN
    assign fwd_valid = w_wen_next && !reset;
    assign fwd_rd    = reset ? '0 : w_sel_rd;
    assign fwd_data  = reset ? '0 : w_sel_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_unit
// Brief    : Directed, table-driven self-checking bench for writeback_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [3:0]  alu_rd;
    logic [31:0] alu_data;
    logic        stall;
    logic        ld_valid;
    logic        ld_ready;
    logic [3:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_offset;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;
    logic [3:0]  rd;
    logic [31:0] data;
    logic        wEn;
`ifdef WB_FORWARD_EN
    logic        fwd_valid;
    logic [3:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    writeback_unit #(.XLEN(32), .ADDRESSLEN(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .stall      (stall),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_funct3  (ld_funct3),
        .ld_offset  (ld_offset),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
`ifdef WB_FORWARD_EN
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data),
`endif
        .rd         (rd),
        .data       (data),
        .wEn        (wEn)
    );

    typedef struct {
        logic [2:0]  funct3;
        logic [1:0]  offset;
        logic [31:0] rdata;
        logic [3:0]  dest;
        logic        exp_wen;
        logic [31:0] exp_data;
    } ld_vec_t;

    ld_vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alu_valid  = 1'b0;
        alu_rd     = '0;
        alu_data   = '0;
        ld_valid   = 1'b0;
        ld_rd      = '0;
        ld_funct3  = '0;
        ld_offset  = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

`ifdef WB_FORWARD_EN
    // fwd_* sampled just before an edge must reappear on the outputs after it.
    logic        p_valid;
    logic [3:0]  p_rd;
    logic [31:0] p_data;
    logic        p_armed = 1'b0;
    always @(negedge clk) begin
        if (p_armed && !reset) begin
            check("fwd_valid", {31'b0, wEn}, {31'b0, p_valid});
            check("fwd_data", data, p_data);
            check("fwd_rd", {28'b0, rd}, {28'b0, p_rd});
        end
        #4;
        p_valid = fwd_valid;
        p_rd    = fwd_rd;
        p_data  = fwd_data;
        p_armed = 1'b1;
    end
`endif

    initial begin
        vecs[0]  = '{3'b000, 2'd0, 32'h8001_0080, 4'd1,  1'b1, 32'hFFFF_FF80};
        vecs[1]  = '{3'b100, 2'd0, 32'h8001_0080, 4'd2,  1'b1, 32'h0000_0080};
        vecs[2]  = '{3'b001, 2'd2, 32'h8001_0080, 4'd3,  1'b1, 32'hFFFF_8001};
        vecs[3]  = '{3'b101, 2'd2, 32'h8001_0080, 4'd4,  1'b1, 32'h0000_8001};
        vecs[4]  = '{3'b010, 2'd1, 32'h8001_0080, 4'd5,  1'b1, 32'h8001_0080};
        vecs[5]  = '{3'b000, 2'd3, 32'h8001_0080, 4'd6,  1'b1, 32'hFFFF_FF80};
        vecs[6]  = '{3'b000, 2'd1, 32'h8001_0080, 4'd7,  1'b1, 32'h0000_0000};
        vecs[7]  = '{3'b000, 2'd2, 32'h8001_0080, 4'd8,  1'b1, 32'h0000_0001};
        vecs[8]  = '{3'b001, 2'd0, 32'h8001_0080, 4'd9,  1'b1, 32'h0000_0080};
        vecs[9]  = '{3'b001, 2'd3, 32'h8001_0080, 4'd10, 1'b1, 32'hFFFF_8001};
        vecs[10] = '{3'b100, 2'd3, 32'h8001_0080, 4'd11, 1'b1, 32'h0000_0080};
        vecs[11] = '{3'b011, 2'd1, 32'h8001_0080, 4'd12, 1'b1, 32'h8001_0080};
        vecs[12] = '{3'b000, 2'd1, 32'h12F4_7E56, 4'd13, 1'b1, 32'h0000_007E};
        vecs[13] = '{3'b000, 2'd2, 32'h12F4_7E56, 4'd14, 1'b1, 32'hFFFF_FFF4};
        vecs[14] = '{3'b101, 2'd1, 32'h12F4_7E56, 4'd15, 1'b1, 32'h0000_7E56};
        vecs[15] = '{3'b001, 2'd2, 32'h12F4_7E56, 4'd0,  1'b0, 32'h0000_12F4};

        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("reset_wEn", {31'b0, wEn}, 32'd0);
        check("reset_rd", {28'b0, rd}, 32'd0);
        check("reset_data", data, 32'd0);
        check("reset_stall", {31'b0, stall}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_ld_ready", {31'b0, ld_ready}, 32'd1);

        // Single ALU write, then idle cycle keeps rd/data.
        alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 32'hDEAD_BEEF;
        step();
        alu_valid = 1'b0;
        check("alu_wEn", {31'b0, wEn}, 32'd1);
        check("alu_rd", {28'b0, rd}, 32'd3);
        check("alu_data", data, 32'hDEAD_BEEF);
        step();
        check("alu_idle_wEn", {31'b0, wEn}, 32'd0);
        check("alu_idle_rd", {28'b0, rd}, 32'd3);
        check("alu_idle_data", data, 32'hDEAD_BEEF);

        // ALU write to x0 is dropped without stalling.
        alu_valid = 1'b1; alu_rd = 4'd0; alu_data = 32'h1;
        step();
        alu_valid = 1'b0;
        check("x0_wEn", {31'b0, wEn}, 32'd0);
        check("x0_stall", {31'b0, stall}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            ld_valid = 1'b1; ld_rd = vecs[i].dest;
            ld_funct3 = vecs[i].funct3; ld_offset = vecs[i].offset;
            step();
            ld_valid = 1'b0;
            check($sformatf("v%0d_busy", i), {31'b0, busy}, 32'd1);
            check($sformatf("v%0d_ld_ready", i), {31'b0, ld_ready}, 32'd0);
            mem_rvalid = 1'b1; mem_rdata = vecs[i].rdata;
            step();
            mem_rvalid = 1'b0;
            check($sformatf("v%0d_wEn", i), {31'b0, wEn}, {31'b0, vecs[i].exp_wen});
            if (vecs[i].exp_wen) begin
                check($sformatf("v%0d_rd", i), {28'b0, rd}, {28'b0, vecs[i].dest});
                check($sformatf("v%0d_data", i), data, vecs[i].exp_data);
            end
            check($sformatf("v%0d_busy_after", i), {31'b0, busy}, 32'd0);
        end

        // Load response collides with an ALU result: ALU goes via the hold buffer.
        ld_valid = 1'b1; ld_rd = 4'd7; ld_funct3 = 3'b010; ld_offset = 2'd0;
        step();
        ld_valid = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
        alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 32'hA;
        step();
        clear_inputs();
        check("col_ld_wEn", {31'b0, wEn}, 32'd1);
        check("col_ld_rd", {28'b0, rd}, 32'd7);
        check("col_ld_data", data, 32'h1122_3344);
        check("col_stall_set", {31'b0, stall}, 32'd1);
        step();
        check("col_alu_wEn", {31'b0, wEn}, 32'd1);
        check("col_alu_rd", {28'b0, rd}, 32'd5);
        check("col_alu_data", data, 32'hA);
        check("col_stall_clr", {31'b0, stall}, 32'd0);
        step();
        check("col_idle_wEn", {31'b0, wEn}, 32'd0);

        // Reset while waiting drops the load; a late response is ignored.
        ld_valid = 1'b1; ld_rd = 4'd9; ld_funct3 = 3'b010;
        step();
        ld_valid = 1'b0;
        check("rst_pre_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        step();
        mem_rvalid = 1'b0;
        check("rst_late_wEn", {31'b0, wEn}, 32'd0);

        // ld_valid in WAIT_MEM is not captured; mem_rvalid in IDLE is ignored.
        ld_valid = 1'b1; ld_rd = 4'd4; ld_funct3 = 3'b010;
        step();
        ld_rd = 4'd6;
        step();
        ld_valid = 1'b0;
        check("wait_busy", {31'b0, busy}, 32'd1);
        check("wait_wEn", {31'b0, wEn}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        check("wait_resp_rd", {28'b0, rd}, 32'd4);
        check("wait_resp_data", data, 32'hCAFE_F00D);
        check("wait_resp_wEn", {31'b0, wEn}, 32'd1);
        mem_rdata = 32'h0BAD_0BAD;
        step();
        mem_rvalid = 1'b0;
        check("idle_rvalid_wEn", {31'b0, wEn}, 32'd0);
        check("idle_rvalid_busy", {31'b0, busy}, 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
